sensor_request_latch: RTL and testbench

- Conditions raw vehicle-loop sensor inputs (TH, NN, NS) into clean, latched service requests for the general traffic FSM; this is the producer side of the sensor→fsm interface.
- Sits between the sensor GPIOs and the fsm, clocked by the internal 10 kHz CLK_10k.
- Per channel: 2-FF synchroniser, debounce, dwell qualification, then a sticky request held until the fsm returns a served acknowledge.

---
 rtl/sensor_request_latch.sv | 176 +++++++++++++++++
 tb/tb_sensor_request_latch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sensor_request_latch.sv
// Sensor channel conditioning: 2-FF sync, debounce FSM, dwell qualification, sticky request.
// Optional stuck-sensor fault detection under `define STUCK_DETECT_EN.
module sensor_request_latch #(
    parameter int N_SENSORS       = 3,
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int DWELL_CYCLES    = 10000,
    parameter int STUCK_CYCLES    = 3000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] sensor_raw,
    input  logic [N_SENSORS-1:0] served,
    output logic [N_SENSORS-1:0] presence,
    output logic [N_SENSORS-1:0] request
`ifdef STUCK_DETECT_EN
    ,
    output logic [N_SENSORS-1:0] fault
`endif
);

    // state    | meaning
    // ABSENT   | no vehicle, presence=0
    // QUAL_ON  | input high, counting towards presence=1
    // PRESENT  | vehicle present, presence=1
    // QUAL_OFF | input low, counting towards presence=0 (presence still 1)
    typedef enum logic [1:0] {ABSENT, QUAL_ON, PRESENT, QUAL_OFF} db_state_e;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_CYCLES);

    logic [N_SENSORS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_SENSORS-1:0] request_q, request_d;
    logic [N_SENSORS-1:0] served_eff;
    db_state_e            state_q [N_SENSORS];
    db_state_e            state_d [N_SENSORS];
    logic [DB_W-1:0]      cnt_q   [N_SENSORS];
    logic [DB_W-1:0]      cnt_d   [N_SENSORS];
    logic [DW_W-1:0]      dwell_q [N_SENSORS];
    logic [DW_W-1:0]      dwell_d [N_SENSORS];

`ifdef STUCK_DETECT_EN
    localparam int ST_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(STUCK_CYCLES);

    logic [N_SENSORS-1:0] fault_q, fault_d;
    logic [ST_W-1:0]      stuck_q [N_SENSORS];
    logic [ST_W-1:0]      stuck_d [N_SENSORS];

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= '0;
            for (int i = 0; i < N_SENSORS; i++) stuck_q[i] <= '0;
        end else if (enable) begin
            fault_q <= fault_d;
            for (int i = 0; i < N_SENSORS; i++) stuck_q[i] <= stuck_d[i];
        end
    end

    always_comb begin
        fault_d = fault_q;
        for (int i = 0; i < N_SENSORS; i++) begin
            stuck_d[i] = stuck_q[i];
            if (!presence[i])
                stuck_d[i] = '0;
            else if (stuck_q[i] != ST_MAX)
                stuck_d[i] = stuck_q[i] + ST_W'(1);
            if (stuck_q[i] == ST_MAX)
                fault_d[i] = 1'b1;
        end
    end

    // A faulted channel calls for service every cycle regardless of the fsm.
    assign served_eff = served & ~fault_q;
    assign request    = request_q | fault_q;
    assign fault      = fault_q;
`else
    assign served_eff = served;
    assign request    = request_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            request_q <= '0;
            for (int i = 0; i < N_SENSORS; i++) begin
                state_q[i] <= ABSENT;
                cnt_q[i]   <= '0;
                dwell_q[i] <= '0;
            end
        end else if (enable) begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            request_q <= request_d;
            for (int i = 0; i < N_SENSORS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                dwell_q[i] <= dwell_d[i];
            end
        end
    end

    always_comb begin
        sync1_d   = sensor_raw;
        sync2_d   = sync1_q;
        request_d = request_q;
        presence  = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            dwell_d[i] = dwell_q[i];
            presence[i] = (state_q[i] == PRESENT) || (state_q[i] == QUAL_OFF);

            // A single-cycle debounce skips the qualifying states entirely.
            case (state_q[i])
                ABSENT: if (sync2_q[i]) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d[i] = PRESENT;
                    end else begin
                        state_d[i] = QUAL_ON;
                        cnt_d[i]   = DB_W'(1);
                    end
                end
                QUAL_ON: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ABSENT;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] + DB_W'(1) == DB_MAX) begin
                        state_d[i] = PRESENT;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DB_W'(1);
                    end
                end
                PRESENT: if (!sync2_q[i]) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d[i] = ABSENT;
                    end else begin
                        state_d[i] = QUAL_OFF;
                        cnt_d[i]   = DB_W'(1);
                    end
                end
                QUAL_OFF: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESENT;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] + DB_W'(1) == DB_MAX) begin
                        state_d[i] = ABSENT;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DB_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ABSENT;
                    cnt_d[i]   = '0;
                end
            endcase

            if (!presence[i] || served_eff[i])
                dwell_d[i] = '0;
            else if (!request_q[i] && dwell_q[i] != DW_MAX)
                dwell_d[i] = dwell_q[i] + DW_W'(1);

            // Acknowledge beats a coincident dwell expiry.
            if (served_eff[i])
                request_d[i] = 1'b0;
            else if (dwell_q[i] == DW_MAX)
                request_d[i] = 1'b1;
        end
    end

endmodule

// File: tb/tb_sensor_request_latch.sv
// Directed bench for sensor_request_latch with DEBOUNCE=4, DWELL=10, STUCK=50.
module tb_sensor_request_latch;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] sensor_raw;
    logic [2:0] served;
    logic [2:0] presence;
    logic [2:0] request;
`ifdef STUCK_DETECT_EN
    logic [2:0] fault;
`endif

    int checks = 0;
    int errors = 0;

    sensor_request_latch #(
        .N_SENSORS(3),
        .DEBOUNCE_CYCLES(4),
        .DWELL_CYCLES(10),
        .STUCK_CYCLES(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sensor_raw(sensor_raw),
        .served(served),
        .presence(presence),
        .request(request)
`ifdef STUCK_DETECT_EN
        ,
        .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        sensor_raw = 3'b000;
        served = 3'b000;
        tick(3);
        reset = 1'b0;
        check("reset_presence", 32'(presence), 32'h0);
        check("reset_request", 32'(request), 32'h0);
`ifdef STUCK_DETECT_EN
        check("reset_fault", 32'(fault), 32'h0);
`endif

        // clean step on channel 0
        sensor_raw = 3'b001;
        tick(5);
        check("step_pres_early", 32'(presence), 32'h0);
        tick(1);
        check("step_pres_6", 32'(presence), 32'h1);
        tick(10);
        check("step_req_early", 32'(request), 32'h0);
        tick(1);
        check("step_req_11", 32'(request), 32'h1);

        // 3-cycle glitch on channel 1
        sensor_raw = 3'b011;
        tick(3);
        sensor_raw = 3'b001;
        tick(10);
        check("glitch_pres", 32'(presence), 32'h1);
        check("glitch_req", 32'(request), 32'h1);

        // 3-cycle dropout while present on channel 1
        sensor_raw = 3'b011;
        tick(6);
        check("drop_pres_on", 32'(presence), 32'h3);
        sensor_raw = 3'b001;
        tick(3);
        sensor_raw = 3'b011;
        tick(8);
        check("drop_pres_hold", 32'(presence), 32'h3);
        sensor_raw = 3'b001;
        tick(8);
        check("drop_pres_off", 32'(presence), 32'h1);
        check("drop_req_sticky", 32'(request), 32'h3);
        served = 3'b010;
        tick(1);
        served = 3'b000;
        check("drop_req_ack", 32'(request), 32'h1);

        // latch and ack on channel 2
        sensor_raw = 3'b101;
        tick(17);
        check("latch_req_set", 32'(request), 32'h5);
        sensor_raw = 3'b001;
        tick(8);
        check("latch_pres_off", 32'(presence), 32'h1);
        check("latch_req_held", 32'(request), 32'h5);
        served = 3'b100;
        tick(1);
        served = 3'b000;
        check("latch_req_clr", 32'(request), 32'h1);
        tick(12);
        check("latch_req_stay", 32'(request), 32'h1);

        // re-arm on channel 0 with served held for 3 cycles
        served = 3'b001;
        tick(1);
        check("rearm_clr", 32'(request), 32'h0);
        tick(2);
        check("rearm_hold0", 32'(request), 32'h0);
        served = 3'b000;
        tick(10);
        check("rearm_early", 32'(request), 32'h0);
        tick(1);
        check("rearm_11", 32'(request), 32'h1);

        // served coinciding with dwell expiry
        served = 3'b001;
        tick(1);
        served = 3'b000;
        tick(10);
        served = 3'b001;
        tick(1);
        served = 3'b000;
        check("coincide_clr", 32'(request), 32'h0);
        tick(10);
        check("coincide_early", 32'(request), 32'h0);
        tick(1);
        check("coincide_rearm", 32'(request), 32'h1);

        // enable freeze mid-dwell; served pulses during freeze are ignored
        served = 3'b001;
        tick(1);
        served = 3'b000;
        tick(5);
        enable = 1'b0;
        served = 3'b001;
        tick(20);
        check("freeze_pres", 32'(presence), 32'h1);
        check("freeze_req", 32'(request), 32'h0);
        served = 3'b000;
        enable = 1'b1;
        tick(5);
        check("resume_early", 32'(request), 32'h0);
        tick(1);
        check("resume_req", 32'(request), 32'h1);

        // reset during QUAL_ON of channel 1
        sensor_raw = 3'b011;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("rst_mid_pres", 32'(presence), 32'h0);
        check("rst_mid_req", 32'(request), 32'h0);
        reset = 1'b0;
        tick(5);
        check("rst_requal_early", 32'(presence), 32'h0);
        tick(1);
        check("rst_requal", 32'(presence), 32'h3);

`ifdef STUCK_DETECT_EN
        tick(40);
        check("stuck_not_yet", 32'(fault), 32'h0);
        tick(15);
        check("stuck_fault", 32'(fault), 32'h3);
        served = 3'b011;
        tick(1);
        served = 3'b000;
        check("stuck_req_forced", 32'(request), 32'h3);
        sensor_raw = 3'b000;
        tick(10);
        check("stuck_pres_off", 32'(presence), 32'h0);
        check("stuck_sticky", 32'(fault), 32'h3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("stuck_reset", 32'(fault), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
